// File: rtl/ifft_ctrl_pkg.sv
// Shared definitions for the FFT/IFFT framing controller: input FSM state
// encodings and the block-exponent normalisation helper.
package ifft_ctrl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SOP    = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  // Shift a sign-extended sample by a signed exponent: right shifts truncate,
  // left shifts saturate to the signed w-bit range; magnitude clamps to w.
  function automatic logic signed [31:0] norm_shift(input logic signed [31:0] x,
                                                    input logic signed [31:0] e,
                                                    input int unsigned w);
    logic signed [63:0] wide;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic [31:0]        mag;
    mag  = e[31] ? 32'(-e) : 32'(e);
    if (mag > w) mag = w;
    hi   = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo   = -(64'sd1 <<< (w - 1));
    wide = {{32{x[31]}}, x};
    if (e[31]) begin
      wide = wide >>> mag;
    end else begin
      wide = wide <<< mag;
      if (wide > hi) wide = hi;
      else if (wide < lo) wide = lo;
    end
    return wide[31:0];
  endfunction

endpackage

// File: rtl/ifft_skid_buf.sv
// Two-entry valid/ready buffer; full throughput with registered outputs.
module ifft_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  logic [W-1:0] e0;
  logic [W-1:0] e1;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign push_ready = (count != 2'd2);
  assign pop_valid  = (count != 2'd0);
  assign pop_data   = e0;
  assign push       = push_valid & push_ready;
  assign pop        = pop_valid & pop_ready;

  // e0 is always the head; e1 holds the second entry when full
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= 2'd0;
      e0    <= '0;
      e1    <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) e0 <= push_data;
          else               e1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            e0 <= push_data;
          end else begin
            e0 <= e1;
            e1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ifft_frame_ctrl.sv
// Framing/handshake controller around the vendor FFT/IFFT core.
// Optional BLOCK_EXP_NORM_EN: normalise output samples by the block exponent.
module ifft_frame_ctrl
  import ifft_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NPOINT_LOG2 = 10,
  parameter int unsigned EXP_W       = 6,
  parameter int unsigned FCNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_inverse,
  input  logic              err_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  output logic              core_sink_valid,
  output logic              core_sink_sop,
  output logic              core_sink_eop,
  output logic [DATA_W-1:0] core_sink_real,
  output logic [DATA_W-1:0] core_sink_imag,
  input  logic              core_sink_ready,
  output logic              core_inverse,
  output logic [1:0]        core_sink_error,
  input  logic              core_source_valid,
  input  logic              core_source_sop,
  input  logic              core_source_eop,
  input  logic [DATA_W-1:0] core_source_real,
  input  logic [DATA_W-1:0] core_source_imag,
  input  logic [EXP_W-1:0]  core_source_exp,
  input  logic [1:0]        core_source_error,
  output logic              core_source_ready,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic [EXP_W-1:0]  out_exp,
  input  logic              out_ready,
  output logic              err_len,
  output logic              err_sop,
  output logic              err_core,
  output logic [FCNT_W-1:0] frames_done
);

  localparam logic [NPOINT_LOG2-1:0] LAST    = '1;
  localparam int unsigned            ENTRY_W = 2 * DATA_W + EXP_W + 2;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
    logic [EXP_W-1:0]  bexp;
    logic              sop;
    logic              eop;
  } entry_t;

  logic [1:0]             state, state_nxt;
  logic [NPOINT_LOG2-1:0] in_cnt, in_cnt_nxt;
  logic                   inv_q, inv_nxt;
  logic                   run, in_xfer;

  // Input path: zero-latency pass-through gated by the framing FSM
  assign run             = reset_n && (state != ST_IDLE);
  assign in_ready        = core_sink_ready & run;
  assign core_sink_valid = in_valid & run;
  assign in_xfer         = in_valid & in_ready;
  assign core_sink_sop   = run && (state == ST_SOP);
  assign core_sink_eop   = run && (in_cnt == LAST);
  assign core_sink_real  = in_real;
  assign core_sink_imag  = in_imag;
  assign core_sink_error = 2'b00;
  assign core_inverse    = core_sink_sop ? cfg_inverse : inv_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      in_cnt <= '0;
      inv_q  <= 1'b1;
    end else begin
      state  <= state_nxt;
      in_cnt <= in_cnt_nxt;
      inv_q  <= inv_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    in_cnt_nxt = in_cnt;
    inv_nxt    = inv_q;
    case (state)
      ST_IDLE: state_nxt = ST_SOP;
      ST_SOP: begin
        if (in_xfer) begin
          inv_nxt    = cfg_inverse;
          in_cnt_nxt = NPOINT_LOG2'(1);
          state_nxt  = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (in_xfer) begin
          if (in_cnt == LAST) begin
            in_cnt_nxt = '0;
            state_nxt  = ST_SOP;
          end else begin
            in_cnt_nxt = in_cnt + NPOINT_LOG2'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  entry_t                 push_entry, head;
  logic                   push_ready, src_xfer, pop;
  logic [NPOINT_LOG2-1:0] out_cnt, out_cnt_nxt;
  logic                   set_len, set_sop, set_core;

  always_comb begin
    push_entry.sop  = core_source_sop;
    push_entry.eop  = core_source_eop;
`ifdef BLOCK_EXP_NORM_EN
    push_entry.re   = DATA_W'(norm_shift(32'(signed'(core_source_real)),
                                         32'(signed'(core_source_exp)), DATA_W));
    push_entry.im   = DATA_W'(norm_shift(32'(signed'(core_source_imag)),
                                         32'(signed'(core_source_exp)), DATA_W));
    push_entry.bexp = '0;
`else
    push_entry.re   = core_source_real;
    push_entry.im   = core_source_imag;
    push_entry.bexp = core_source_exp;
`endif
  end

  ifft_skid_buf #(.W(ENTRY_W)) u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_valid (core_source_valid),
    .push_ready (push_ready),
    .push_data  (push_entry),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (head)
  );

  assign core_source_ready = push_ready & reset_n;
  assign src_xfer          = core_source_valid & core_source_ready;
  assign pop               = out_valid & out_ready;
  assign out_real          = head.re;
  assign out_imag          = head.im;
  assign out_exp           = head.bexp;
  assign out_sop           = head.sop;
  assign out_eop           = head.eop;

  // Source framing check: sop resyncs the count, eop/length mismatch restarts it
  always_comb begin
    out_cnt_nxt = out_cnt;
    set_len     = 1'b0;
    set_sop     = 1'b0;
    set_core    = 1'b0;
    if (src_xfer) begin
      set_core = (core_source_error != 2'b00);
      if (core_source_sop && (out_cnt != '0)) begin
        set_sop     = 1'b1;
        out_cnt_nxt = NPOINT_LOG2'(1);
      end else if (core_source_eop || (out_cnt == LAST)) begin
        set_len     = !(core_source_eop && (out_cnt == LAST));
        out_cnt_nxt = '0;
      end else begin
        out_cnt_nxt = out_cnt + NPOINT_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_cnt     <= '0;
      err_len     <= 1'b0;
      err_sop     <= 1'b0;
      err_core    <= 1'b0;
      frames_done <= '0;
    end else begin
      out_cnt  <= out_cnt_nxt;
      err_len  <= set_len  | (err_len  & ~err_clr);
      err_sop  <= set_sop  | (err_sop  & ~err_clr);
      err_core <= set_core | (err_core & ~err_clr);
      if (pop && head.eop) frames_done <= frames_done + FCNT_W'(1);
    end
  end

endmodule
